// File: rtl/note_player.sv
// note_player: melody sequencer and square-wave tone generator.
// Steps a 6-bit note index through 64 slots, one step every TEMPO_DIV cycles.
// The index addresses an external combinational ROM. The divider value the ROM
// returns sets the half-period of audio_o in clock cycles. Divider 0 is a rest.
// Optional feature macro: NOTE_PLAYER_GAP_EN. When it is defined, the tone is
// silenced for the last GAP_CYCLES cycles of every step so that repeated
// notes are heard as separate notes.
module note_player #(
  parameter int BW         = 16,
  parameter int TEMPO_BW   = 24,
  parameter int TEMPO_DIV  = 1800000,
  parameter int GAP_CYCLES = 120000
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          loop_i,
  input  logic [BW-1:0] dividerValue_i,
  output logic [5:0]    noteIndex_o,
  output logic          audio_o,
  output logic          busy_o,
  output logic          noteStrobe_o,
  output logic          done_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  localparam logic [TEMPO_BW-1:0] TEMPO_LAST = TEMPO_BW'(TEMPO_DIV - 1);

  // Catch illegal tempo and gap settings at elaboration time.
  if (TEMPO_DIV < 2 || TEMPO_DIV > (2 ** TEMPO_BW) - 1 || GAP_CYCLES >= TEMPO_DIV) begin : g_bad_params
    $error("note_player: TEMPO_DIV or GAP_CYCLES out of range");
  end

  state_t              r_state, w_state_nxt;
  logic [5:0]          r_index, w_index_nxt;
  logic [TEMPO_BW-1:0] r_tempo, w_tempo_nxt;
  logic [BW-1:0]       r_tone,  w_tone_nxt;
  logic                r_audio, w_audio_nxt;
  logic                r_strobe, w_strobe_nxt;
  logic                r_done,  w_done_nxt;

  logic                w_step_end;
  logic                w_gap;
  logic [TEMPO_BW-1:0] w_tempo_inc;

  assign w_step_end  = (r_tempo == TEMPO_LAST);
  assign w_tempo_inc = r_tempo + TEMPO_BW'(1);

  // The gap test uses the incremented tempo so that audio_o is already low in
  // the first cycle whose tempo count reaches TEMPO_DIV - GAP_CYCLES.
`ifdef NOTE_PLAYER_GAP_EN
  localparam logic [TEMPO_BW-1:0] GAP_START = TEMPO_BW'(TEMPO_DIV - GAP_CYCLES);
  assign w_gap = (w_tempo_inc >= GAP_START);
`else
  assign w_gap = 1'b0;
`endif

  // All state lives in one register bank, which keeps the outputs glitch-free.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= ST_IDLE;
      r_index  <= '0;
      r_tempo  <= '0;
      r_tone   <= '0;
      r_audio  <= 1'b0;
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, whatever order these lines are written in.
      r_state  <= w_state_nxt;
      r_index  <= w_index_nxt;
      r_tempo  <= w_tempo_nxt;
      r_tone   <= w_tone_nxt;
      r_audio  <= w_audio_nxt;
      r_strobe <= w_strobe_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Next-state logic: sequencing, step boundaries and the tone counter.
  always_comb begin
    // NOTE: every output of this block gets a default first. A path that
    // left one unassigned would infer a latch.
    w_state_nxt  = r_state;
    w_index_nxt  = r_index;
    w_tempo_nxt  = r_tempo;
    w_tone_nxt   = r_tone;
    w_audio_nxt  = r_audio;
    w_strobe_nxt = 1'b0;
    w_done_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start_i && !stop_i) begin
          w_state_nxt  = ST_PLAY;
          w_index_nxt  = '0;
          w_tempo_nxt  = '0;
          w_tone_nxt   = '0;
          w_audio_nxt  = 1'b0;
          w_strobe_nxt = 1'b1;
        end
      end

      ST_PLAY: begin
        if (stop_i) begin
          w_state_nxt = ST_IDLE;
          w_index_nxt = '0;
          w_tempo_nxt = '0;
          w_tone_nxt  = '0;
          w_audio_nxt = 1'b0;
        end else if (w_step_end) begin
          w_tempo_nxt = '0;
          w_tone_nxt  = '0;
          w_audio_nxt = 1'b0;
          if (r_index == 6'd63) begin
            if (loop_i) begin
              w_index_nxt  = '0;
              w_strobe_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
              w_index_nxt = '0;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_index_nxt  = r_index + 6'd1;
            w_strobe_nxt = 1'b1;
          end
        end else begin
          w_tempo_nxt = w_tempo_inc;
          if (w_gap || dividerValue_i == '0) begin
            w_tone_nxt  = '0;
            w_audio_nxt = 1'b0;
          end else if (r_tone >= dividerValue_i - BW'(1)) begin
            // >= (rather than ==) recovers in one cycle when the divider shrinks.
            w_tone_nxt  = '0;
            w_audio_nxt = ~r_audio;
          end else begin
            w_tone_nxt = r_tone + BW'(1);
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_index_nxt = '0;
        w_tempo_nxt = '0;
        w_tone_nxt  = '0;
        w_audio_nxt = 1'b0;
      end
    endcase
  end

  assign noteIndex_o  = r_index;
  assign audio_o      = r_audio;
  assign busy_o       = (r_state == ST_PLAY);
  assign noteStrobe_o = r_strobe;
  assign done_o       = r_done;

endmodule

// File: tb/tb_note_player.sv
// tb_note_player: directed test of note_player with TEMPO_DIV=64, GAP_CYCLES=8.
// The ROM is stood in for by a divider that is fixed, except at index 2,
// which is a rest.
module tb_note_player;

  localparam int BW  = 16;
  localparam int TD  = 64;
  localparam int GAP = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic          loop_en;
  logic [BW-1:0] divider;
  logic [5:0]    note_index;
  logic          audio;
  logic          busy;
  logic          strobe;
  logic          done;

  logic [BW-1:0] div_base;
  logic          rest_en;

  int n_cmp = 0;
  int n_err = 0;

  note_player #(
    .BW        (BW),
    .TEMPO_BW  (24),
    .TEMPO_DIV (TD),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .start_i       (start),
    .stop_i        (stop),
    .loop_i        (loop_en),
    .dividerValue_i(divider),
    .noteIndex_o   (note_index),
    .audio_o       (audio),
    .busy_o        (busy),
    .noteStrobe_o  (strobe),
    .done_o        (done)
  );

  // Combinational ROM stand-in.
  assign divider = (rest_en && note_index == 6'd2) ? '0 : div_base;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected audio level j cycles after a step starts, for divider d.
  function automatic logic exp_audio(input int j, input int d);
    if (d == 0) return 1'b0;
`ifdef NOTE_PLAYER_GAP_EN
    if (j >= TD - GAP) return 1'b0;
`endif
    return ((j / d) % 2) == 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    loop_en  = 1'b0;
    div_base = 16'd4;
    rest_en  = 1'b1;

    // Reset values.
    #12;
    check("rst_index",  32'(note_index), 32'd0);
    check("rst_audio",  32'(audio),      32'd0);
    check("rst_busy",   32'(busy),       32'd0);
    check("rst_strobe", 32'(strobe),     32'd0);
    check("rst_done",   32'(done),       32'd0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_busy",   32'(busy),   32'd0);
    check("idle_strobe", 32'(strobe), 32'd0);

    // Start: index 0 and a strobe right after the sampling edge.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy",   32'(busy),       32'd1);
    check("start_index",  32'(note_index), 32'd0);
    check("start_strobe", 32'(strobe),     32'd1);
    check("start_audio",  32'(audio),      32'd0);

    // Steps 0..3: divider 4 (period 8, first rise 4 cycles in), with index 2 a rest.
    for (int s = 0; s < 4; s++) begin
      for (int j = 1; j < TD; j++) begin
        tick();
        check($sformatf("audio_s%0d_j%0d", s, j), 32'(audio), 32'(exp_audio(j, (s == 2) ? 0 : 4)));
        if (j == 1)  check($sformatf("no_strobe_s%0d", s), 32'(strobe), 32'd0);
        if (j == 63) check($sformatf("index_hold_s%0d", s), 32'(note_index), 32'(s));
      end
      tick();
      check($sformatf("step_index_%0d", s + 1),  32'(note_index), 32'(s + 1));
      check($sformatf("step_strobe_%0d", s + 1), 32'(strobe),     32'd1);
      check($sformatf("step_audio_%0d", s + 1),  32'(audio),      32'd0);
    end

    // Run to index 10, then stop partway through the step while audio is high.
    repeat (6 * TD) tick();
    check("index10",        32'(note_index), 32'd10);
    check("index10_strobe", 32'(strobe),     32'd1);
    repeat (5) tick();
    check("pre_stop_audio", 32'(audio), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy",   32'(busy),       32'd0);
    check("stop_index",  32'(note_index), 32'd0);
    check("stop_audio",  32'(audio),      32'd0);
    check("stop_done",   32'(done),       32'd0);
    check("stop_strobe", 32'(strobe),     32'd0);
    repeat (3) tick();
    check("stop_stays_idle", 32'(busy), 32'd0);

    // start and stop together while idle: stays idle.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("startstop_busy",   32'(busy),   32'd0);
    check("startstop_strobe", 32'(strobe), 32'd0);
    tick();
    check("startstop_busy2", 32'(busy), 32'd0);

    // Full sequence with loop off; start held for an extra cycle is ignored.
    loop_en = 1'b0;
    start   = 1'b1;
    tick();
    check("seq_start_strobe", 32'(strobe), 32'd1);
    check("seq_start_busy",   32'(busy),   32'd1);
    tick();
    start = 1'b0;
    check("start_ignored_strobe", 32'(strobe),     32'd0);
    check("start_ignored_index",  32'(note_index), 32'd0);
    check("start_ignored_busy",   32'(busy),       32'd1);
    repeat (64 * TD - 2) tick();
    check("last_index",     32'(note_index), 32'd63);
    check("last_busy",      32'(busy),       32'd1);
    check("last_done_low",  32'(done),       32'd0);
    tick();
    check("done_pulse",     32'(done),       32'd1);
    check("done_busy_low",  32'(busy),       32'd0);
    check("done_index",     32'(note_index), 32'd0);
    check("done_no_strobe", 32'(strobe),     32'd0);
    tick();
    check("done_single",    32'(done),       32'd0);
    check("done_idle",      32'(busy),       32'd0);

    // Full sequence with loop on: wrap 63 -> 0 with a strobe, no done.
    loop_en = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (64 * TD - 1) tick();
    check("loop_last_index", 32'(note_index), 32'd63);
    tick();
    check("wrap_index",  32'(note_index), 32'd0);
    check("wrap_strobe", 32'(strobe),     32'd1);
    check("wrap_busy",   32'(busy),       32'd1);
    check("wrap_done",   32'(done),       32'd0);
    repeat (4) tick();
    check("wrap_audio_hi", 32'(audio), 32'd1);
    check("wrap_busy2",    32'(busy),  32'd1);
    check("wrap_done2",    32'(done),  32'd0);

    // Asynchronous reset mid-cycle while playing with audio high.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_audio",  32'(audio),      32'd0);
    check("arst_busy",   32'(busy),       32'd0);
    check("arst_index",  32'(note_index), 32'd0);
    check("arst_strobe", 32'(strobe),     32'd0);
    check("arst_done",   32'(done),       32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_busy",  32'(busy),  32'd0);
    check("post_rst_audio", 32'(audio), 32'd0);

    // Divider 1 toggles every cycle.
    div_base = 16'd1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      tick();
      check($sformatf("div1_j%0d", j), 32'(audio), 32'(exp_audio(j, 1)));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("div1_stop_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/note_player.md
# note_player

Sequencer and tone generator that consumes the note ROM. It steps a 6-bit note index through all 64 melody slots at a fixed tempo and reads the combinational divider value returned for each index. It drives a square-wave `audio_o` whose half-period is that divider value in clock cycles, and it sits between the ROM and the top-level audio output pin.

## Interface
- `BW`, 16: width of the divider value.
- `TEMPO_BW`, 24: width of the tempo counter.
- `TEMPO_DIV`, 1800000: clock cycles per note step (150 ms at 12 MHz); legal range 2 .. 2^TEMPO_BW-1.
- `GAP_CYCLES`, 120000: silent cycles at the end of each step; used only with `NOTE_PLAYER_GAP_EN`; must be < `TEMPO_DIV`.

- `clk_i` in 1: single clock; all logic on its rising edge.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: level-sampled; begins playback from index 0 when idle.
- `stop_i` in 1: aborts playback; has priority over `start_i`.
- `loop_i` in 1: sampled at the index-63 step boundary; 1 = wrap to 0, 0 = finish.
- `dividerValue_i` in BW: ROM output for `noteIndex_o`; 0 = rest.
- `noteIndex_o` out 6: current note index, fed to the ROM address.
- `audio_o` out 1: square-wave tone output.
- `busy_o` out 1: high while playing.
- `noteStrobe_o` out 1: one-cycle pulse in the first cycle that a new index is presented.
- `done_o` out 1: one-cycle pulse when a non-looping playback completes.

## Operation
- **Reset values:** state IDLE, `noteIndex_o`=0, `audio_o`=0, `busy_o`=0, `noteStrobe_o`=0, `done_o`=0, all counters 0.
- **States:** IDLE and PLAY.
- **IDLE → PLAY:** `start_i`=1 and `stop_i`=0. Index=0, tempo count=0, tone count=0, `audio_o`=0, `noteStrobe_o`=1.
- **PLAY, tempo counter:** increments each cycle. At `TEMPO_DIV`-1 it clears and the index advances by 1, with `noteStrobe_o`=1, tone count=0 and `audio_o`=0 on the boundary.
- **Index 63 at step end with `loop_i`=1:** index wraps to 0 with a strobe; `busy_o` stays high.
- **Index 63 at step end with `loop_i`=0:** go to IDLE, index=0, `done_o`=1 for one cycle, `busy_o`=0.
- **`stop_i`=1 in any state:** next cycle IDLE, index=0, `audio_o`=0, counters cleared. No `done_o` pulse.
- **`start_i` in PLAY:** ignored. `start_i` and `stop_i` together in IDLE: remain IDLE.
- **Tone, divider = 0:** tone count held at 0 and `audio_o`=0.
- **Tone, divider ≠ 0:** tone count increments. When count ≥ divider-1, count clears and `audio_o` toggles. Using ≥ makes a shrinking divider self-correct within one cycle.
- **Tone frequency:** f_clk / (2·divider). Divider 1 toggles every cycle.
- **Divider sampling:** `dividerValue_i` is sampled every cycle, with no register between the ROM and the tone counter.
- **Tempo counter:** must not overflow. The comparison is made at `TEMPO_BW` width.

## Timing
- `start_i` sampled high at edge N: at N+1 `busy_o`=1, `noteIndex_o`=0, `noteStrobe_o`=1.
- Step k begins at edge N+1+k·`TEMPO_DIV`.
- First `audio_o` rise for divider d: d cycles after the step starts.
- Completion (loop off): `done_o` asserts at N+1+64·`TEMPO_DIV`, the same cycle `busy_o` falls.
- `stop_i` at edge M: IDLE values visible at M+1.
- `rst_n_i` low: outputs take reset values immediately, independent of `clk_i`. Release is synchronised externally.

## Configuration
- **`NOTE_PLAYER_GAP_EN` defined:** during the last `GAP_CYCLES` cycles of each step (tempo count ≥ `TEMPO_DIV`-`GAP_CYCLES`), `audio_o` is forced to 0 and the tone count is held at 0. This articulates repeated notes, e.g. E5 at indices 0 and 1.
- **Not defined:** the tone plays for the full step, repeated notes merge into one, and `GAP_CYCLES` is unused.

## Test plan
- **Reset:** assert `rst_n_i`=0 mid-PLAY with `audio_o`=1 → `audio_o`, `busy_o`, `noteIndex_o`, `noteStrobe_o` and `done_o` all 0 asynchronously; after release the block stays IDLE until `start_i`.
- **Tone and step rate:** `TEMPO_DIV`=64, `dividerValue_i` tied to 4, `start_i` pulse → `audio_o` period 8 cycles, first rise 4 cycles after the strobe; `noteStrobe_o` every 64 cycles; index counts 0,1,2…
- **Rest:** `dividerValue_i`=0 for index 2 → `audio_o` stays 0 for all 64 cycles of that step; tone resumes at index 3.
- **End of sequence:** `TEMPO_DIV`=4, `loop_i`=0 → `done_o` single pulse and `busy_o` falls at cycle 1+256. Same run with `loop_i`=1 → index 63→0 with a strobe, no `done_o`.
- **Stop handling:** `stop_i` at index 10 → next cycle IDLE, `audio_o`=0, index 0. `start_i`=`stop_i`=1 while IDLE → `busy_o` stays 0.
- **Gap (macro defined, `TEMPO_DIV`=64, `GAP_CYCLES`=8, divider 2):** `audio_o` toggles for 56 cycles, then is 0 for 8 cycles per step. With the macro undefined, `audio_o` toggles for all 64 cycles.
